// File: rtl/etapa_fetch_pc.sv
// -----------------------------------------------------------------------------
// etapa_fetch_pc
//   Fetch stage that sits directly in front of the instruction ROM. It holds
//   the program counter, drives the ROM read address and captures the
//   returned word into the IF/ID pipeline register. It also handles hazard
//   stalls, branch/jump redirects and a sticky halt request, and it counts
//   the instructions it delivers (saturating).
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   stall          in   hold PC and IF/ID (hazard unit)
//   redirect       in   taken branch/jump from a later stage
//   redirect_pc    in   redirect target address
//   halt_req       in   stop fetching until the next reset
//   direinstru     out  ROM read address (the pc register itself)
//   instru         in   ROM data, combinational from direinstru
//   ifid_instr     out  registered instruction word
//   ifid_pc        out  address of ifid_instr
//   ifid_pc_plus1  out  ifid_pc + 1 (wraps)
//   ifid_valid     out  ifid_instr holds a real instruction
//   halted         out  stage is in HALT
//   fetch_count    out  number of valid instructions delivered, saturating
// -----------------------------------------------------------------------------
module etapa_fetch_pc #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] direinstru,
  input  logic [DATA_W-1:0] instru,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus1,
  output logic              ifid_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;

  // The ROM address is the pc register itself, so the ROM sees it without
  // any extra logic in between.
  assign direinstru = pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      ifid_instr    <= NOP_WORD;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      halted        <= 1'b0;
      fetch_count   <= '0;
    end else begin
      case (state_reg)
        // One dead cycle after reset so the ROM output settles on the reset
        // address before it is captured. All control inputs are ignored here.
        BOOT: begin
          ifid_valid <= 1'b0;
          ifid_instr <= NOP_WORD;
          state_reg  <= RUN;
        end

        RUN: begin
          if (redirect) begin
            // Flush wins even over a stall: the fetched word is wrong-path.
            pc_reg     <= redirect_pc;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
          end else if (halt_req) begin
            state_reg  <= HALT;
            ifid_valid <= 1'b0;
            halted     <= 1'b1;
          end else if (!stall) begin
            ifid_instr    <= instru;
            ifid_pc       <= pc_reg;
            ifid_pc_plus1 <= pc_reg + 1'b1;
            ifid_valid    <= 1'b1;
            pc_reg        <= pc_reg + 1'b1;
            if (fetch_count != CNT_MAX) begin
              fetch_count <= fetch_count + 1'b1;
            end
          end
          // stall without redirect/halt: everything holds.
        end

        // Sticky until reset; redirect and stall have no effect.
        HALT: begin
          ifid_valid <= 1'b0;
          halted     <= 1'b1;
        end

        default: begin
          state_reg  <= BOOT;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
